// File: rtl/tcm_pkg.sv
// Shared definitions for the TCM port arbiter: FSM state encodings
// and small helpers for requester-index arithmetic.
package tcm_pkg;

    typedef enum logic [1:0] {
        TCM_IDLE  = 2'd0,
        TCM_ISSUE = 2'd1,
        TCM_WAIT  = 2'd2
    } tcm_state_t;

    // Width of a requester index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (p + off) mod n, for p < n and off < n.
    function automatic int rr_wrap(input int p, input int off, input int n);
        int s;
        s = p + off;
        if (s >= n) s = s - n;
        return s;
    endfunction

endpackage

// File: rtl/tcm_port_arbiter_rr_pick.sv
// Rotate-priority encoder: lowest index >= ptr with req set, wrapping.
// Ports: req (request vector), ptr (start index), valid (any req), idx (winner).
module rr_pick
    import tcm_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IW    = idx_w(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    ptr,
    output logic             valid,
    output logic [IW-1:0]    idx
);

    // Scan from the farthest offset down so the nearest one wins last.
    always_comb begin
        valid = |req;
        idx   = '0;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            if (req[rr_wrap(int'(ptr), off, N_REQ)]) begin
                idx = IW'(rr_wrap(int'(ptr), off, N_REQ));
            end
        end
    end

endmodule

// File: rtl/tcm_port_arbiter.sv
// Round-robin arbiter sharing one TCM SRAM port among N_REQ requesters.
// Ports: req/we/be/addr/wdata per requester in, rdata/ready out,
// busy_o, and the SRAM en/we/be/addr/wdata/rdata/ready port.
module tcm_port_arbiter
    import tcm_pkg::*;
#(
    parameter int N_REQ      = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDRW      = 10
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic [N_REQ-1:0]              req_i,
    input  logic [N_REQ-1:0]              we_i,
    input  logic [N_REQ*DATA_WIDTH/8-1:0] be_i,
    input  logic [N_REQ*ADDRW-1:0]        addr_i,
    input  logic [N_REQ*DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]         rdata_o,
    output logic [N_REQ-1:0]              ready_o,
    output logic                          busy_o,
    output logic                          sram_en_o,
    output logic                          sram_we_o,
    output logic [DATA_WIDTH/8-1:0]       sram_be_o,
    output logic [ADDRW-1:0]              sram_addr_o,
    output logic [DATA_WIDTH-1:0]         sram_wdata_o,
    input  logic [DATA_WIDTH-1:0]         sram_rdata_i,
    input  logic                          sram_ready_i
);

    localparam int IW   = idx_w(N_REQ);
    localparam int BE_W = DATA_WIDTH / 8;

    tcm_state_t state;
    tcm_state_t state_nxt;

    logic [IW-1:0]         ptr;
    logic [IW-1:0]         grant;
    logic                  lat_we;
    logic [BE_W-1:0]       lat_be;
    logic [ADDRW-1:0]      lat_addr;
    logic [DATA_WIDTH-1:0] lat_wdata;

    logic          pick_valid;
    logic [IW-1:0] pick_idx;
    logic          take;
    logic          done;

    rr_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req   (req_i),
        .ptr   (ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign take = (state == TCM_IDLE) && pick_valid;
    assign done = (state == TCM_WAIT) && sram_ready_i;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) state <= TCM_IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            TCM_IDLE:  if (pick_valid)   state_nxt = TCM_ISSUE;
            TCM_ISSUE:                   state_nxt = TCM_WAIT;
            TCM_WAIT:  if (sram_ready_i) state_nxt = TCM_IDLE;
            default:                     state_nxt = TCM_IDLE;
        endcase
    end

    // Latched request copy and rotating pointer
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ptr       <= '0;
            grant     <= '0;
            lat_we    <= 1'b0;
            lat_be    <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else begin
            if (take) begin
                grant     <= pick_idx;
                lat_we    <= we_i[pick_idx];
                lat_be    <= be_i[pick_idx*BE_W +: BE_W];
                lat_addr  <= addr_i[pick_idx*ADDRW +: ADDRW];
                lat_wdata <= wdata_i[pick_idx*DATA_WIDTH +: DATA_WIDTH];
            end
            if (done) begin
                if (int'(grant) == N_REQ - 1) ptr <= '0;
                else                          ptr <= grant + 1'b1;
            end
        end
    end

    // Output decode; SRAM fields are zero outside ISSUE.
    // ready_o is suppressed under reset so an aborted access never completes.
    always_comb begin
        busy_o       = (state != TCM_IDLE);
        sram_en_o    = 1'b0;
        sram_we_o    = 1'b0;
        sram_be_o    = '0;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        ready_o      = '0;
        if (state == TCM_ISSUE) begin
            sram_en_o    = 1'b1;
            sram_we_o    = lat_we;
            sram_be_o    = lat_be;
            sram_addr_o  = lat_addr;
            sram_wdata_o = lat_wdata;
        end
        if (done && !rst_i) ready_o[grant] = 1'b1;
    end

    assign rdata_o = sram_rdata_i;

endmodule
